// File: rtl/uart_frame_parser_if.sv
// Byte-in / payload-out stream bundle for uart_frame_parser.
// slave: the parser side; master: the UART receiver plus payload sink side.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_ready;
    logic       pld_last;

    modport master (output rx_data, rx_flag, pld_ready,
                    input  pld_data, pld_valid, pld_last);
    modport slave  (input  rx_data, rx_flag, pld_ready,
                    output pld_data, pld_valid, pld_last);
endinterface

// File: rtl/uart_frame_parser.sv
// Finds 55 AA LEN PAYLOAD CHK frames in a UART byte stream and releases checksum-verified payloads.
// Optional FRAME_STATS_EN macro builds saturating good-frame and error counters.
module uart_frame_parser #(
    parameter int unsigned CLK       = 100_000_000,
    parameter int unsigned BPS       = 9600,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned TMO_BYTES = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_frame_parser_if.slave   bus,
    output logic [7:0]           pld_len,
    output logic                 err_flag,
    output logic [2:0]           err_code,
    output logic [15:0]          ok_cnt,
    output logic [15:0]          err_cnt
);
    localparam int unsigned TMO_CYC = (CLK / BPS) * TMO_BYTES;
    localparam int unsigned TW      = $clog2(TMO_CYC + 1);
    localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] E_LEN = 3'd1;
    localparam logic [2:0] E_CHK = 3'd2;
    localparam logic [2:0] E_TMO = 3'd3;
    localparam logic [2:0] E_OVR = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_HDR1, S_LEN, S_PLD, S_CHK, S_DRAIN} state_t;

    state_t          state;
    logic [7:0]      len;
    logic [7:0]      sum;
    logic [7:0]      idx;
    logic [7:0]      rd;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      buf_mem [MAX_LEN];
    logic            tmo_hit_c;

    assign tmo_hit_c = (tmo_cnt == TW'(TMO_CYC - 1)) && !bus.rx_flag;

    // Payload buffer has no reset; contents are only read after being written by the current frame.
    always_ff @(posedge clk) begin
        if (state == S_PLD && bus.rx_flag)
            buf_mem[AW'(idx)] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            len           <= '0;
            sum           <= '0;
            idx           <= '0;
            rd            <= '0;
            tmo_cnt       <= '0;
            bus.pld_data  <= '0;
            bus.pld_valid <= 1'b0;
            bus.pld_last  <= 1'b0;
            pld_len       <= '0;
            err_flag      <= 1'b0;
            err_code      <= '0;
        end else begin
            err_flag <= 1'b0;
            // Inter-byte timer only runs while a frame is being collected
            if (bus.rx_flag || state == S_IDLE || state == S_DRAIN)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            case (state)
                S_IDLE: begin
                    if (bus.rx_flag && bus.rx_data == 8'h55)
                        state <= S_HDR1;
                end
                S_HDR1, S_LEN, S_PLD, S_CHK: begin
                    if (bus.rx_flag) begin
                        case (state)
                            S_HDR1: begin
                                if (bus.rx_data == 8'hAA)      state <= S_LEN;
                                else if (bus.rx_data != 8'h55) state <= S_IDLE;
                            end
                            S_LEN: begin
                                if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > MAX_LEN) begin
                                    err_flag <= 1'b1;
                                    err_code <= E_LEN;
                                    state    <= S_IDLE;
                                end else begin
                                    len   <= bus.rx_data;
                                    sum   <= bus.rx_data;
                                    idx   <= '0;
                                    state <= S_PLD;
                                end
                            end
                            S_PLD: begin
                                sum <= 8'(sum + bus.rx_data);
                                idx <= 8'(idx + 8'd1);
                                if (idx == 8'(len - 8'd1))
                                    state <= S_CHK;
                            end
                            default: begin
                                if (bus.rx_data == sum) begin
                                    bus.pld_valid <= 1'b1;
                                    bus.pld_data  <= buf_mem[0];
                                    bus.pld_last  <= (len == 8'd1);
                                    pld_len       <= len;
                                    rd            <= '0;
                                    state         <= S_DRAIN;
                                end else begin
                                    err_flag <= 1'b1;
                                    err_code <= E_CHK;
                                    state    <= S_IDLE;
                                end
                            end
                        endcase
                    end else if (tmo_hit_c) begin
                        err_flag <= 1'b1;
                        err_code <= E_TMO;
                        state    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (bus.rx_flag) begin
                        err_flag <= 1'b1;
                        err_code <= E_OVR;
                    end
                    // Next byte is preloaded into the output register on each accepted transfer
                    if (bus.pld_valid && bus.pld_ready) begin
                        if (bus.pld_last) begin
                            bus.pld_valid <= 1'b0;
                            bus.pld_last  <= 1'b0;
                            state         <= S_IDLE;
                        end else begin
                            rd           <= 8'(rd + 8'd1);
                            bus.pld_data <= buf_mem[AW'(8'(rd + 8'd1))];
                            bus.pld_last <= (8'(rd + 8'd1) == 8'(len - 8'd1));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_STATS_EN
    logic chk_pass_c;
    assign chk_pass_c = (state == S_CHK) && bus.rx_flag && (bus.rx_data == sum);

    // Saturating frame statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (chk_pass_c && ok_cnt != 16'hFFFF) ok_cnt  <= ok_cnt + 16'd1;
            if (err_flag && err_cnt != 16'hFFFF)  err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign ok_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: scoreboard queues for payload bytes and error codes.
module tb_uart_frame_parser;
    localparam int unsigned TMO_CYC = 200;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } pld_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pld_len;
    logic        err_flag;
    logic [2:0]  err_code;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    pld_t       exp_q[$];
    logic [2:0] err_q[$];
    logic [7:0] seq[$];

    uart_frame_parser_if bus();

    uart_frame_parser #(.CLK(1000), .BPS(100), .MAX_LEN(16), .TMO_BYTES(20)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .pld_len(pld_len), .err_flag(err_flag),
        .err_code(err_code), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: payload transfers and error pulses are matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pld_valid) check("pld_expected", 32'(exp_q.size() != 0), 1);
            if (bus.pld_valid && bus.pld_ready && exp_q.size() != 0) begin
                pld_t e;
                e = exp_q.pop_front();
                check("pld_data", bus.pld_data, e.d);
                check("pld_last", bus.pld_last, e.l);
            end
            if (err_flag) begin
                check("err_expected", 32'(err_q.size() != 0), 1);
                if (err_q.size() != 0) check("err_code", err_code, err_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        @(posedge clk); #1;
        bus.rx_flag = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic push_pld(input logic [7:0] d, input logic l);
        pld_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            done = (exp_q.size() == 0) && (err_q.size() == 0) && !bus.pld_valid;
        end
        check(tag, 32'(done), 1);
    endtask

    initial begin
        bit held;
        rst_n         = 1'b0;
        bus.rx_data   = '0;
        bus.rx_flag   = 1'b0;
        bus.pld_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.pld_valid, 0);
        check("rst_data", bus.pld_data, 0);
        check("rst_last", bus.pld_last, 0);
        check("rst_len", pld_len, 0);
        check("rst_err", {err_flag, err_code}, 0);
        check("rst_cnt", {ok_cnt, err_cnt}, 0);
        rst_n = 1'b1;

        // T1 good frame, with first-byte latency check
        push_pld(8'h11, 0); push_pld(8'h22, 0); push_pld(8'h33, 1);
        seq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        check("t1_latency_valid", bus.pld_valid, 1);
        check("t1_latency_data", bus.pld_data, 8'h11);
        wait_idle("t1_done", 50);
        check("t1_pld_len", pld_len, 3);

        // T2 checksum error
        err_q.push_back(3'd2);
        seq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
        send_seq();
        wait_idle("t2_done", 50);

        // T3 bad LEN (zero and too long), then a good frame
        err_q.push_back(3'd1);
        seq = '{8'h55, 8'hAA, 8'h00};
        send_seq();
        wait_idle("t3a_done", 50);
        err_q.push_back(3'd1);
        seq = '{8'h55, 8'hAA, 8'h11};
        send_seq();
        wait_idle("t3b_done", 50);
        push_pld(8'h11, 0); push_pld(8'h22, 0); push_pld(8'h33, 1);
        seq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        wait_idle("t3c_done", 50);

        // T4 resync through junk and repeated 0x55
        push_pld(8'h7E, 1);
        seq = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_seq();
        wait_idle("t4_done", 50);
        check("t4_pld_len", pld_len, 1);

        // T5 timeout mid-payload, then recovery
        err_q.push_back(3'd3);
        seq = '{8'h55, 8'hAA, 8'h02, 8'h11};
        send_seq();
        wait_idle("t5_timeout", TMO_CYC + 50);
        push_pld(8'h05, 1);
        seq = '{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06};
        send_seq();
        wait_idle("t5_recover", 50);
        check("t5_code_held", err_code, 3);

        // Reset during a stalled drain abandons the frame
        bus.pld_ready = 1'b0;
        seq = '{8'h55, 8'hAA, 8'h01, 8'h42, 8'h43};
        send_seq();
        check("rm_valid_before", bus.pld_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rm_valid_in_rst", bus.pld_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.pld_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rm_valid_after", bus.pld_valid, 0);
        check("rm_len_after", pld_len, 0);

        // T6 backpressure hold, overrun during drain
        bus.pld_ready = 1'b0;
        push_pld(8'h11, 0); push_pld(8'h22, 0); push_pld(8'h33, 1);
        seq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        held = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!bus.pld_valid || bus.pld_data !== 8'h11 || bus.pld_last !== 1'b0) held = 1'b0;
        end
        check("t6_hold", 32'(held), 1);
        err_q.push_back(3'd4);
        send_byte(8'hA5);
        check("t6_data_after_ovr", bus.pld_data, 8'h11);
        bus.pld_ready = 1'b1;
        wait_idle("t6_done", 50);
`ifdef FRAME_STATS_EN
        check("t6_ok_cnt", ok_cnt, 1);
        check("t6_err_cnt", err_cnt, 1);
`else
        check("t6_ok_cnt", ok_cnt, 0);
        check("t6_err_cnt", err_cnt, 0);
`endif
        check("t6_pld_len", pld_len, 3);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
